// File: rtl/d_sram_bridge.sv
// d_sram_bridge
//   Bridges the M-stage data access of an in-order MIPS-style pipeline onto an
//   SRAM-like bus with separate address and data handshakes. Each access
//   produces exactly one bus transaction, with request fields held stable
//   until the bus accepts them. Load data is returned in a held register.
//
// Parameters
//   KSEG_MAP       1: kseg0/kseg1 virtual addresses are mapped to physical
//                  addresses. 0: addresses pass through unchanged.
// Ports
//   clk            pipeline clock, rising edge
//   resetn         synchronous active-low reset
//   cpu_en         M-stage access valid (already exception gated)
//   cpu_wen[3:0]   byte write strobes, 0 = load
//   cpu_addr[31:0] virtual byte address
//   cpu_wdata      lane-aligned store data
//   longest_stall  global pipeline stall, M stage holds while 1
//   cpu_rdata      load data returned to the CPU
//   d_stall        data-side stall request to the hazard unit
//   data_req/wr/size/addr/wdata   bus request channel
//   data_addr_ok   bus accepted the request
//   data_data_ok   read data valid / write completed
//   data_rdata     bus read data
module d_sram_bridge #(
   parameter bit KSEG_MAP = 1'b1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        cpu_en,
   input  logic [3:0]  cpu_wen,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   input  logic        longest_stall,
   output logic [31:0] cpu_rdata,
   output logic        d_stall,
   output logic        data_req,
   output logic        data_wr,
   output logic [1:0]  data_size,
   output logic [31:0] data_addr,
   output logic [31:0] data_wdata,
   input  logic        data_addr_ok,
   input  logic        data_data_ok,
   input  logic [31:0] data_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

   state_t      state_q, state_d;
   logic        wr_q, wr_d;
   logic [1:0]  size_q, size_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;

   logic [1:0]  req_size;
   logic [1:0]  req_lo;
   logic [31:0] phys_addr;
   logic        rd_done;

   // Store strobes decide the transfer size and the low address bits.
   // Loads and irregular strobe patterns fall back to an aligned word.
   always_comb begin
      req_size = 2'd2;
      req_lo   = 2'b00;
      case (cpu_wen)
         4'b0011: begin req_size = 2'd1; req_lo = 2'b00; end
         4'b1100: begin req_size = 2'd1; req_lo = 2'b10; end
         4'b0001: begin req_size = 2'd0; req_lo = 2'b00; end
         4'b0010: begin req_size = 2'd0; req_lo = 2'b01; end
         4'b0100: begin req_size = 2'd0; req_lo = 2'b10; end
         4'b1000: begin req_size = 2'd0; req_lo = 2'b11; end
         default: begin req_size = 2'd2; req_lo = 2'b00; end
      endcase
   end

   // kseg0 (100) and kseg1 (101) are unmapped windows onto the low 512 MB.
   always_comb begin
      phys_addr = {cpu_addr[31:2], req_lo};
      if (KSEG_MAP && (cpu_addr[31:29] == 3'b100 || cpu_addr[31:29] == 3'b101)) begin
         phys_addr = {3'b000, cpu_addr[28:2], req_lo};
      end
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         wr_q    <= 1'b0;
         size_q  <= 2'd0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         size_q  <= size_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   // Next-state logic. data_data_ok before address acceptance is ignored;
   // once issued, the access always runs to completion even if flushed.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (cpu_en) state_d = S_REQ;
         S_REQ:  if (data_addr_ok) state_d = data_data_ok ? S_DONE : S_WAIT;
         S_WAIT: if (data_data_ok) state_d = S_DONE;
         S_DONE: if (!longest_stall) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Request fields latch only on IDLE -> REQ so they stay put under back-pressure.
   assign rd_done = !wr_q && data_data_ok &&
                    ((state_q == S_REQ && data_addr_ok) || state_q == S_WAIT);

   always_comb begin
      wr_d    = wr_q;
      size_d  = size_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      if (state_q == S_IDLE && cpu_en) begin
         wr_d    = (cpu_wen != 4'b0000);
         size_d  = req_size;
         addr_d  = phys_addr;
         wdata_d = cpu_wdata;
      end
      if (rd_done) begin
         rdata_d = data_rdata;
      end
   end

   // Outputs
   always_comb begin
      data_req   = (state_q == S_REQ);
      d_stall    = cpu_en && (state_q != S_DONE);
      data_wr    = wr_q;
      data_size  = size_q;
      data_addr  = addr_q;
      data_wdata = wdata_q;
      cpu_rdata  = rdata_q;
   end

endmodule

// File: tb/tb_d_sram_bridge.sv
module tb_d_sram_bridge;

   logic        clk = 1'b0;
   logic        resetn;
   logic        cpu_en;
   logic [3:0]  cpu_wen;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic        longest_stall;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;

   logic [31:0] cpu_rdata, data_addr, data_wdata;
   logic        d_stall, data_req, data_wr;
   logic [1:0]  data_size;

   logic [31:0] r_cpu_rdata, r_data_addr, r_data_wdata;
   logic        r_d_stall, r_data_req, r_data_wr;
   logic [1:0]  r_data_size;

   int checks = 0;
   int failures = 0;
   int txn = 0;

   always #5 clk = ~clk;

   d_sram_bridge #(.KSEG_MAP(1'b1)) u_dut (
      .clk(clk), .resetn(resetn), .cpu_en(cpu_en), .cpu_wen(cpu_wen),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .longest_stall(longest_stall),
      .cpu_rdata(cpu_rdata), .d_stall(d_stall), .data_req(data_req),
      .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
      .data_data_ok(data_data_ok), .data_rdata(data_rdata)
   );

   d_sram_bridge #(.KSEG_MAP(1'b0)) u_raw (
      .clk(clk), .resetn(resetn), .cpu_en(cpu_en), .cpu_wen(cpu_wen),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .longest_stall(longest_stall),
      .cpu_rdata(r_cpu_rdata), .d_stall(r_d_stall), .data_req(r_data_req),
      .data_wr(r_data_wr), .data_size(r_data_size), .data_addr(r_data_addr),
      .data_wdata(r_data_wdata), .data_addr_ok(data_addr_ok),
      .data_data_ok(data_data_ok), .data_rdata(data_rdata)
   );

   // Accepted bus requests on the mapped instance.
   always @(posedge clk) begin
      if (resetn && data_req && data_addr_ok) txn <= txn + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one clock edge; inputs may then be changed and outputs sampled.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      resetn = 1'b0; cpu_en = 1'b0; cpu_wen = 4'd0; cpu_addr = 32'd0;
      cpu_wdata = 32'd0; longest_stall = 1'b0; data_addr_ok = 1'b0;
      data_data_ok = 1'b0; data_rdata = 32'd0;
      tick(); tick();

      // Reset values; d_stall stays combinational during reset
      chk("rst_req", {31'd0, data_req}, 32'd0);
      chk("rst_wr", {31'd0, data_wr}, 32'd0);
      chk("rst_size", {30'd0, data_size}, 32'd0);
      chk("rst_addr", data_addr, 32'd0);
      chk("rst_wdata", data_wdata, 32'd0);
      chk("rst_rdata", cpu_rdata, 32'd0);
      cpu_en = 1'b1; settle();
      chk("rst_dstall", {31'd0, d_stall}, 32'd1);
      tick();
      chk("rst_hold_req", {31'd0, data_req}, 32'd0);
      cpu_en = 1'b0;
      resetn = 1'b1;
      tick();

      // Load at kseg0: addr_ok cycle 2, data_ok cycle 4
      cpu_en = 1'b1; cpu_wen = 4'b0000; cpu_addr = 32'h8000_1234; cpu_wdata = 32'h5555_5555;
      settle();
      chk("ld_c1_dstall", {31'd0, d_stall}, 32'd1);
      chk("ld_c1_req", {31'd0, data_req}, 32'd0);
      tick();
      data_addr_ok = 1'b1; settle();
      chk("ld_c2_req", {31'd0, data_req}, 32'd1);
      chk("ld_addr", data_addr, 32'h0000_1234);
      chk("ld_size", {30'd0, data_size}, 32'd2);
      chk("ld_wr", {31'd0, data_wr}, 32'd0);
      chk("ld_c2_dstall", {31'd0, d_stall}, 32'd1);
      tick();
      data_addr_ok = 1'b0; settle();
      chk("ld_c3_req", {31'd0, data_req}, 32'd0);
      chk("ld_c3_dstall", {31'd0, d_stall}, 32'd1);
      tick();
      data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF; settle();
      chk("ld_c4_dstall", {31'd0, d_stall}, 32'd1);
      tick();
      data_data_ok = 1'b0; data_rdata = 32'h0; settle();
      chk("ld_c5_dstall", {31'd0, d_stall}, 32'd0);
      chk("ld_rdata", cpu_rdata, 32'hDEAD_BEEF);
      tick();
      cpu_en = 1'b0;
      chk("ld_txn", txn, 32'd1);

      // Stray data_ok in IDLE is ignored
      data_data_ok = 1'b1; data_rdata = 32'h1111_1111;
      tick();
      data_data_ok = 1'b0;
      chk("idle_dok_req", {31'd0, data_req}, 32'd0);
      chk("idle_dok_rdata", cpu_rdata, 32'hDEAD_BEEF);

      // Store byte at kseg1 with same-cycle addr_ok/data_ok
      cpu_en = 1'b1; cpu_wen = 4'b0100; cpu_addr = 32'hA000_0010; cpu_wdata = 32'h00AB_0000;
      tick();
      chk("sb_req", {31'd0, data_req}, 32'd1);
      chk("sb_wr", {31'd0, data_wr}, 32'd1);
      chk("sb_size", {30'd0, data_size}, 32'd0);
      chk("sb_addr", data_addr, 32'h0000_0012);
      chk("sb_wdata", data_wdata, 32'h00AB_0000);
      data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h1234_5678;
      tick();
      data_addr_ok = 1'b0; data_data_ok = 1'b0; settle();
      chk("sb_done_dstall", {31'd0, d_stall}, 32'd0);
      chk("sb_done_req", {31'd0, data_req}, 32'd0);
      chk("sb_rdata_kept", cpu_rdata, 32'hDEAD_BEEF);
      tick();
      cpu_en = 1'b0;
      chk("sb_txn", txn, 32'd2);

      // Back-pressure: halfword store, cpu_en dropped, early data_ok ignored
      cpu_en = 1'b1; cpu_wen = 4'b1100; cpu_addr = 32'h1234_5678; cpu_wdata = 32'hBEEF_0000;
      tick();
      cpu_en = 1'b0; cpu_addr = 32'h8000_0000; cpu_wen = 4'b0001; cpu_wdata = 32'h0;
      for (int i = 0; i < 5; i++) begin
         data_data_ok = (i == 2);
         settle();
         chk("bp_req", {31'd0, data_req}, 32'd1);
         chk("bp_addr", data_addr, 32'h1234_567A);
         chk("bp_size", {30'd0, data_size}, 32'd1);
         chk("bp_wr", {31'd0, data_wr}, 32'd1);
         chk("bp_wdata", data_wdata, 32'hBEEF_0000);
         tick();
      end
      data_data_ok = 1'b0; data_addr_ok = 1'b1;
      tick();
      data_addr_ok = 1'b0;
      chk("bp_wait_req", {31'd0, data_req}, 32'd0);
      data_data_ok = 1'b1; data_rdata = 32'h7777_7777;
      tick();
      data_data_ok = 1'b0;
      tick();
      chk("bp_txn", txn, 32'd3);
      chk("bp_rdata_kept", cpu_rdata, 32'hDEAD_BEEF);

      // Global stall holds DONE; no second request
      longest_stall = 1'b1;
      cpu_en = 1'b1; cpu_wen = 4'b0000; cpu_addr = 32'h0000_0100;
      tick();
      chk("gs_addr", data_addr, 32'h0000_0100);
      data_addr_ok = 1'b1;
      tick();
      data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D;
      tick();
      data_data_ok = 1'b0;
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("gs_dstall", {31'd0, d_stall}, 32'd0);
         chk("gs_req", {31'd0, data_req}, 32'd0);
         tick();
      end
      chk("gs_rdata", cpu_rdata, 32'hCAFE_F00D);
      longest_stall = 1'b0;
      tick();
      settle();
      chk("gs_idle_dstall", {31'd0, d_stall}, 32'd1);
      chk("gs_idle_req", {31'd0, data_req}, 32'd0);
      chk("gs_txn", txn, 32'd4);

      // Next access enters WAIT, then reset aborts it
      tick();
      chk("rw_req", {31'd0, data_req}, 32'd1);
      data_addr_ok = 1'b1;
      tick();
      data_addr_ok = 1'b0; resetn = 1'b0;
      tick();
      cpu_en = 1'b0; settle();
      chk("rw_req0", {31'd0, data_req}, 32'd0);
      chk("rw_addr0", data_addr, 32'd0);
      chk("rw_size0", {30'd0, data_size}, 32'd0);
      chk("rw_rdata0", cpu_rdata, 32'd0);
      resetn = 1'b1;
      data_data_ok = 1'b1; data_rdata = 32'h9999_9999;
      tick();
      data_data_ok = 1'b0;
      chk("rw_orphan_rdata", cpu_rdata, 32'd0);

      // Pass-through when mapping disabled, and kseg2 passes even when enabled
      cpu_en = 1'b1; cpu_wen = 4'b0000; cpu_addr = 32'h8000_0000;
      tick();
      chk("km_map_addr", data_addr, 32'h0000_0000);
      chk("km_raw_addr", r_data_addr, 32'h8000_0000);
      chk("km_raw_req", {31'd0, r_data_req}, 32'd1);
      data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h0BAD_F00D;
      tick();
      data_addr_ok = 1'b0; data_data_ok = 1'b0;
      tick();
      chk("km_raw_rdata", r_cpu_rdata, 32'h0BAD_F00D);

      // Irregular strobe pattern at kseg2
      cpu_wen = 4'b0101; cpu_addr = 32'hC000_0007; cpu_wdata = 32'h00FF_00FF;
      tick();
      cpu_en = 1'b0;
      chk("odd_size", {30'd0, data_size}, 32'd2);
      chk("odd_addr", data_addr, 32'hC000_0004);
      chk("odd_wr", {31'd0, data_wr}, 32'd1);
      data_addr_ok = 1'b1; data_data_ok = 1'b1;
      tick();
      data_addr_ok = 1'b0; data_data_ok = 1'b0;
      tick();
      chk("odd_rdata_kept", cpu_rdata, 32'h0BAD_F00D);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/d_sram_bridge.md
D_SRAM_BRIDGE -- requirements
Module: d_sram_bridge

Interface
REQ-001 Parameter KSEG_MAP, default 1, meaning: 1 = translate kseg0/kseg1 addresses to physical; 0 = pass addresses through unchanged.
REQ-002 clk  input  1  pipeline clock; all state changes on its rising edge.
REQ-003 resetn  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 cpu_en  input  1  M-stage data access valid; already gated by exception.
REQ-005 cpu_wen  input  4  byte write strobes (selM & memwriteM); 0 means load.
REQ-006 cpu_addr  input  32  virtual byte address (aluoutM).
REQ-007 cpu_wdata  input  32  lane-aligned store data.
REQ-008 longest_stall  input  1  global pipeline stall; 1 means the M stage holds.
REQ-009 cpu_rdata  output  32  load data returned to the CPU.
REQ-010 d_stall  output  1  data-side stall request to the hazard unit.
REQ-011 data_req  output  1  bus request valid.
REQ-012 data_wr  output  1  1 = write, 0 = read.
REQ-013 data_size  output  2  0 = byte, 1 = half, 2 = word.
REQ-014 data_addr  output  32  physical byte address.
REQ-015 data_wdata  output  32  store data.
REQ-016 data_addr_ok  input  1  bus accepted the request this cycle.
REQ-017 data_data_ok  input  1  read data is valid, or the write completed, this cycle.
REQ-018 data_rdata  input  32  bus read data.

Function
REQ-019 FSM states: IDLE, REQ, WAIT, DONE.
REQ-020 IDLE -> REQ when cpu_en=1.
REQ-021 REQ -> WAIT on data_addr_ok=1.
REQ-022 In REQ, if data_addr_ok=1 and data_data_ok=1 in the same cycle, the transition is REQ -> DONE and the read data is captured.
REQ-023 WAIT -> DONE on data_data_ok=1.
REQ-024 DONE -> IDLE when longest_stall=0; DONE holds while longest_stall=1.
REQ-025 data_req=1 exactly while the state is REQ.
REQ-026 Once data_req is asserted, it and all request fields stay constant until data_addr_ok, even if cpu_en drops.
REQ-027 Request fields (wr, size, addr, wdata) are registered on the IDLE -> REQ transition.
REQ-028 data_wr = (cpu_wen != 0) at capture.
REQ-029 Store size/address, by cpu_wen: 1111 -> size 2, addr[1:0]=00; 0011 -> size 1, 00; 1100 -> size 1, 10; 0001/0010/0100/1000 -> size 0, 00/01/10/11.
REQ-030 Any other non-zero cpu_wen -> size 2, addr[1:0]=00.
REQ-031 Loads: size 2, addr[1:0]=00; byte/half extraction is done downstream.
REQ-032 KSEG_MAP=1: cpu_addr[31:29] of 100 or 101 -> data_addr[31:29]=000; all other addresses pass unchanged.
REQ-033 cpu_rdata: register loaded from data_rdata on the completing data_data_ok of a read; held until the next read completes.
REQ-034 Writes do not modify cpu_rdata.
REQ-035 d_stall = cpu_en & (state != DONE), combinational.
REQ-036 Latency: minimum 3 cycles from cpu_en to d_stall=0 (IDLE, REQ with addr_ok and data_ok in the same cycle, DONE).
REQ-037 If cpu_en=0 when a response arrives (flushed mid-access), the FSM still completes the access; DONE exits on longest_stall=0.
REQ-038 Exactly one bus transaction per access; no new request is issued from DONE.
REQ-039 data_data_ok seen in IDLE or REQ before data_addr_ok is ignored.

Reset
REQ-040 When resetn=0 at a clock edge: state IDLE, data_req=0, data_wr=0, data_size=0, data_addr=0, data_wdata=0, cpu_rdata=0.
REQ-041 Reset overrides any in-flight transaction; the outstanding response is not tracked.
REQ-042 d_stall follows REQ-035 during and after reset.

Verification
REQ-043 Load: cpu_en=1, cpu_wen=0, cpu_addr=0x8000_1234; addr_ok on cycle 2, data_ok with 0xDEADBEEF on cycle 4 -> data_addr=0x0000_1234, size 2, wr 0; d_stall=1 for cycles 1-4 and 0 from cycle 5; cpu_rdata=0xDEADBEEF.
REQ-044 Store byte: cpu_wen=0100, cpu_addr=0xA000_0010 -> data_wr=1, size 0, data_addr=0x0000_0012; cpu_rdata unchanged.
REQ-045 Back-pressure: data_addr_ok held 0 for 5 cycles and cpu_en dropped at cycle 2 -> data_req and all fields stable for the 5 cycles; exactly one transaction.
REQ-046 Global stall: completion occurs with longest_stall=1 for 3 cycles -> FSM stays in DONE, d_stall=0, no second request; IDLE after longest_stall falls.
REQ-047 Same-cycle addr_ok and data_ok in REQ -> DONE next cycle; data captured.
REQ-048 resetn=0 while in WAIT -> state IDLE, all outputs at reset values on the next edge; KSEG_MAP=0 case: 0x8000_0000 passes through unchanged.
